// File: rtl/sdp_x_mul_op_feeder.sv
// SDP X-stage multiplier operand feeder: packs RDMA beats into wide words
// through a 2-entry FIFO, or replicates the per-layer register operand.
module sdp_x_mul_op_feeder #(
  parameter int IN_W  = 64,
  parameter int OUT_W = 256,
  parameter int CNT_W = 16
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rstn,
  input  logic             cfg_mul_src,
  input  logic [15:0]      cfg_mul_op,
  input  logic [CNT_W-1:0] cfg_op_cnt,
  input  logic             op_start,
  output logic             op_done,
  input  logic             op_in_pvld,
  output logic             op_in_prdy,
  input  logic [IN_W-1:0]  op_in_pd,
  output logic [OUT_W-1:0] chn_mul_op_rsc_z,
  output logic             chn_mul_op_rsc_vz,
  input  logic             chn_mul_op_rsc_lz
);
  localparam int BEATS = OUT_W / IN_W;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int REP   = OUT_W / 16;
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic             src_q, src_d;
  logic [15:0]      op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [CNT_W-1:0] packed_q, packed_d;
  logic [CNT_W-1:0] sent_q, sent_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0] fifo_q [2];
  logic [OUT_W-1:0] fifo_d [2];
  logic             wr_q, wr_d;
  logic             rd_q, rd_d;
  logic [1:0]       fcnt_q, fcnt_d;
  logic             done_q, done_d;

  logic             run, full, pop, fpop;
  logic             beat_acc, push, last_pop;
  logic [OUT_W-1:0] word;

  always_comb begin
    run  = (state_q == RUN);
    full = (fcnt_q == 2'd2);
    if (src_q) chn_mul_op_rsc_vz = (fcnt_q != 2'd0);
    else       chn_mul_op_rsc_vz = run & (sent_q < cnt_q);
    chn_mul_op_rsc_z = src_q ? fifo_q[rd_q] : {REP{op_q}};
    pop  = chn_mul_op_rsc_vz & chn_mul_op_rsc_lz;
    fpop = pop & src_q;
    // a full FIFO only blocks the word-completing beat, and not if it drains now
    op_in_prdy = run & src_q & (packed_q < cnt_q)
               & ~((beat_q == LAST) & full & ~pop);
    beat_acc = op_in_pvld & op_in_prdy;
    push     = beat_acc & (beat_q == LAST);
    word     = acc_q;
    word[int'(LAST)*IN_W +: IN_W] = op_in_pd;
    last_pop = pop & (sent_q == cnt_q - CNT_W'(1));
  end

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    beat_d   = beat_q;
    packed_d = packed_q;
    sent_d   = sent_q;
    acc_d    = acc_q;
    fifo_d   = fifo_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    fcnt_d   = fcnt_q;
    done_d   = 1'b0;
    if (beat_acc) begin
      acc_d[int'(beat_q)*IN_W +: IN_W] = op_in_pd;
      beat_d = (beat_q == LAST) ? '0 : beat_q + BW'(1);
    end
    if (push) begin
      fifo_d[wr_q] = word;
      wr_d         = ~wr_q;
      packed_d     = packed_q + CNT_W'(1);
    end
    if (pop) sent_d = sent_q + CNT_W'(1);
    if (fpop) rd_d = ~rd_q;
    unique case ({push, fpop})
      2'b10:   fcnt_d = fcnt_q + 2'd1;
      2'b01:   fcnt_d = fcnt_q - 2'd1;
      default: fcnt_d = fcnt_q;
    endcase
    unique case (state_q)
      IDLE: begin
        if (op_start) begin
          src_d    = cfg_mul_src;
          op_d     = cfg_mul_op;
          cnt_d    = cfg_op_cnt;
          beat_d   = '0;
          packed_d = '0;
          sent_d   = '0;
          wr_d     = 1'b0;
          rd_d     = 1'b0;
          fcnt_d   = 2'd0;
          if (cfg_op_cnt == '0) done_d = 1'b1;
          else                  state_d = RUN;
        end
      end
      RUN: begin
        if (last_pop) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q   <= IDLE;
      src_q     <= 1'b0;
      op_q      <= '0;
      cnt_q     <= '0;
      beat_q    <= '0;
      packed_q  <= '0;
      sent_q    <= '0;
      acc_q     <= '0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      fcnt_q    <= 2'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      beat_q    <= beat_d;
      packed_q  <= packed_d;
      sent_q    <= sent_d;
      acc_q     <= acc_d;
      fifo_q[0] <= fifo_d[0];
      fifo_q[1] <= fifo_d[1];
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      fcnt_q    <= fcnt_d;
      done_q    <= done_d;
    end
  end

  assign op_done = done_q;

endmodule

// File: tb/tb_sdp_x_mul_op_feeder.sv
// Directed bench for sdp_x_mul_op_feeder: packing, backpressure,
// register mode, zero-length layers, reset abort and a long random run.
module tb_sdp_x_mul_op_feeder;
  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         src = 1'b0;
  logic [15:0]  mop = '0;
  logic [15:0]  cnt = '0;
  logic         start = 1'b0;
  logic         pvld = 1'b0;
  logic [63:0]  pd = '0;
  logic         lz = 1'b0;
  logic         done, prdy, vz;
  logic [255:0] z;

  int passed = 0;
  int fails = 0;
  int total = 0;
  int to_cnt = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int cons_cyc = 0;
  int acc_beats = 0;
  int cons = 0;
  int max_occ = 0;
  int prdy_seen = 0;
  int d0;
  logic [255:0] got [$];
  logic [255:0] exp_q [$];
  logic [255:0] rep;

  always #5 clk = ~clk;

  sdp_x_mul_op_feeder dut (
    .nvdla_core_clk   (clk),
    .nvdla_core_rstn  (rstn),
    .cfg_mul_src      (src),
    .cfg_mul_op       (mop),
    .cfg_op_cnt       (cnt),
    .op_start         (start),
    .op_done          (done),
    .op_in_pvld       (pvld),
    .op_in_prdy       (prdy),
    .op_in_pd         (pd),
    .chn_mul_op_rsc_z (z),
    .chn_mul_op_rsc_vz(vz),
    .chn_mul_op_rsc_lz(lz)
  );

  // inputs only change 2-3 time units after posedge, so the negedge view
  // is exactly what the next posedge will act on
  always @(negedge clk) begin
    cyc++;
    if ((acc_beats / 4 - cons) > max_occ) max_occ = acc_beats / 4 - cons;
    if (vz && lz) begin
      got.push_back(z);
      cons++;
      cons_cyc = cyc;
    end
    if (pvld && prdy) acc_beats++;
    if (prdy) prdy_seen++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_layer(input logic s, input logic [15:0] m,
                             input logic [15:0] c);
    src = s;
    mop = m;
    cnt = c;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [63:0] d);
    int n;
    n = 0;
    pvld = 1'b1;
    pd = d;
    #1;
    while (!prdy && n < 200) begin
      tick();
      #1;
      n++;
    end
    if (n >= 200) to_cnt++;
    @(posedge clk);
    #2;
    pvld = 1'b0;
  endtask

  task automatic wait_done(input int base, input int lim);
    int n;
    n = 0;
    while (done_cnt == base && n < lim) begin
      tick();
      n++;
    end
    if (done_cnt == base) to_cnt++;
  endtask

  function automatic logic [255:0] w4(input logic [63:0] a, input logic [63:0] b,
                                      input logic [63:0] c, input logic [63:0] d);
    return {d, c, b, a};
  endfunction

  initial begin
    rep = {16{16'hABCD}};
    repeat (3) tick();
    #1;
    chk("rst_vz", vz, 0);
    chk("rst_prdy", prdy, 0);
    chk("rst_z", z, 0);
    chk("rst_done", done, 0);
    rstn = 1'b1;
    tick();

    // T2: two packed words, lz tied high
    lz = 1'b1;
    got.delete();
    d0 = done_cnt;
    start_layer(1'b1, 16'h0, 16'd2);
    for (int i = 1; i <= 8; i++) send_beat(64'(i));
    wait_done(d0, 50);
    chk("t2_nwords", got.size(), 2);
    chk("t2_z0", got[0], w4(1, 2, 3, 4));
    chk("t2_z1", got[1], w4(5, 6, 7, 8));
    chk("t2_done_lat", done_cyc - cons_cyc, 1);
    tick();
    #1;
    chk("t2_done_pulse", done, 0);
    chk("t2_ndone", done_cnt - d0, 1);
    tick();

    // T3: FIFO full blocks only the word-completing beat
    lz = 1'b0;
    got.delete();
    d0 = done_cnt;
    start_layer(1'b1, 16'h0, 16'd4);
    for (int i = 1; i <= 11; i++) send_beat(64'(i));
    pvld = 1'b1;
    pd = 64'd12;
    #1;
    chk("t3_blk", prdy, 0);
    chk("t3_vz", vz, 1);
    chk("t3_z", z, w4(1, 2, 3, 4));
    repeat (3) tick();
    #1;
    chk("t3_blk_hold", prdy, 0);
    chk("t3_z_hold", z, w4(1, 2, 3, 4));
    lz = 1'b1;
    #1;
    chk("t3_pop_rdy", prdy, 1);
    @(posedge clk);
    #2;
    lz = 1'b0;
    pvld = 1'b0;
    #1;
    chk("t3_head", z, w4(5, 6, 7, 8));
    chk("t3_one_pop", got.size(), 1);
    lz = 1'b1;
    for (int i = 13; i <= 16; i++) send_beat(64'(i));
    wait_done(d0, 50);
    chk("t3_nwords", got.size(), 4);
    chk("t3_w0", got[0], w4(1, 2, 3, 4));
    chk("t3_w2", got[2], w4(9, 10, 11, 12));
    chk("t3_w3", got[3], w4(13, 14, 15, 16));
    tick();

    // T4: register mode with random lz
    lz = 1'b1;
    src = 1'b0;
    tick();
    #1;
    chk("t4_idle_vz", vz, 0);
    got.delete();
    prdy_seen = 0;
    d0 = done_cnt;
    start_layer(1'b0, 16'hABCD, 16'd3);
    #1;
    chk("t4_vz", vz, 1);
    chk("t4_z", z, rep);
    for (int n = 0; n < 200 && done_cnt == d0; n++) begin
      lz = 1'($urandom_range(0, 1));
      tick();
    end
    if (done_cnt == d0) to_cnt++;
    lz = 1'b1;
    repeat (3) tick();
    chk("t4_ncons", got.size(), 3);
    for (int i = 0; i < got.size(); i++) chk("t4_word", got[i], rep);
    chk("t4_prdy_never", prdy_seen, 0);
    chk("t4_vz_end", vz, 0);

    // T5: empty layer, then op_start during RUN is ignored
    lz = 1'b0;
    d0 = done_cnt;
    start_layer(1'b1, 16'h0, 16'd0);
    #1;
    chk("t5_done0", done, 1);
    chk("t5_vz0", vz, 0);
    tick();
    #1;
    chk("t5_done0_clr", done, 0);
    chk("t5_vz0b", vz, 0);
    chk("t5_prdy0", prdy, 0);
    got.delete();
    lz = 1'b1;
    start_layer(1'b1, 16'h0, 16'd1);
    cnt = 16'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) send_beat(64'h100 + 64'(i));
    wait_done(d0 + 1, 50);
    repeat (3) tick();
    #1;
    chk("t5_ncons", got.size(), 1);
    chk("t5_word", got[0], w4(64'h100, 64'h101, 64'h102, 64'h103));
    chk("t5_prdy_end", prdy, 0);
    chk("t5_ndone", done_cnt - d0, 2);

    // T1: reset mid-layer with two words queued
    lz = 1'b0;
    start_layer(1'b1, 16'h0, 16'd4);
    for (int i = 0; i < 8; i++) send_beat(64'h200 + 64'(i));
    tick();
    #1;
    chk("t1_queued", vz, 1);
    rstn = 1'b0;
    #1;
    chk("t1_vz", vz, 0);
    chk("t1_prdy", prdy, 0);
    chk("t1_z", z, 0);
    chk("t1_done", done, 0);
    tick();
    rstn = 1'b1;
    tick();
    got.delete();
    lz = 1'b1;
    d0 = done_cnt;
    start_layer(1'b1, 16'h0, 16'd1);
    for (int i = 0; i < 4; i++) send_beat(64'h300 + 64'(i));
    wait_done(d0, 50);
    chk("t1_ncons", got.size(), 1);
    chk("t1_word", got[0], w4(64'h300, 64'h301, 64'h302, 64'h303));
    tick();

    // T6: long run with random valid gaps and load backpressure
    lz = 1'b0;
    acc_beats = 0;
    cons = 0;
    max_occ = 0;
    got.delete();
    exp_q.delete();
    d0 = done_cnt;
    start_layer(1'b1, 16'h0, 16'd1000);
    fork
      begin
        logic [255:0] e;
        logic [63:0]  d;
        e = '0;
        for (int w = 0; w < 1000; w++) begin
          for (int k = 0; k < 4; k++) begin
            d = {$urandom, $urandom};
            e[k*64 +: 64] = d;
            repeat ($urandom_range(0, 2)) tick();
            send_beat(d);
          end
          exp_q.push_back(e);
        end
      end
      begin
        int n;
        n = 0;
        while (done_cnt == d0 && n < 60000) begin
          lz = 1'($urandom_range(0, 1));
          tick();
          n++;
        end
      end
    join
    if (done_cnt == d0) to_cnt++;
    lz = 1'b0;
    chk("t6_nwords", got.size(), 1000);
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chk("t6_word", got[i], exp_q[i]);
    chk("t6_no_overflow", max_occ <= 2, 1);
    chk("timeouts", to_cnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
